// File: rtl/harmonic_sequencer_pkg.sv
// synth_pkg: shared constants, state encoding and output saturation for the synth datapath
package synth_pkg;
    localparam logic [7:0] DAC_CMD_CH_A = 8'h31;
    localparam int SAMPLE_INTERVAL_DEF = 1500;
    localparam int NUM_HARMONICS_DEF = 20;
    typedef enum logic [2:0] {CLEAR, ISSUE, GAP, DRAIN, SCALE, HOLD} seq_state_e;
    function automatic logic [15:0] sat_u16(input logic signed [31:0] v);
        return (v < 0) ? 16'h0000 : ((v > 32'sd65535) ? 16'hFFFF : v[15:0]);
    endfunction
endpackage

// File: rtl/harmonic_sequencer_if.sv
// harmonic_sequencer_if: sequencer links to sine LUT, scaling accumulator and DAC transmitter
interface harmonic_sequencer_if #(parameter int DIV_BIT = 7);
    logic [7:0] o_harmonic;
    logic o_next_sample;
    logic i_sample_ready;
    logic o_adder_start;
    logic o_adder_clear;
    logic [DIV_BIT-1:0] o_adder_mult;
    logic i_adder_ready;
    logic signed [31:0] i_adder_total;
    logic [23:0] o_dac_data;
    logic o_dac_send;
    modport master (
        output o_harmonic, o_next_sample, o_adder_start, o_adder_clear, o_adder_mult, o_dac_data, o_dac_send,
        input i_sample_ready, i_adder_ready, i_adder_total
    );
    modport slave (
        input o_harmonic, o_next_sample, o_adder_start, o_adder_clear, o_adder_mult, o_dac_data, o_dac_send,
        output i_sample_ready, i_adder_ready, i_adder_total
    );
endinterface

// File: rtl/harmonic_sequencer_tick.sv
// sample_tick_gen: one-cycle tick every SAMPLE_INTERVAL clocks, free-running
module sample_tick_gen
    import synth_pkg::*;
#(
    parameter int SAMPLE_INTERVAL = SAMPLE_INTERVAL_DEF
) (
    input  logic fpga_clock,
    input  logic reset,
    output logic tick_o
);
    localparam int W = $clog2(SAMPLE_INTERVAL);
    logic [W-1:0] count_q;
    assign tick_o = count_q == W'(SAMPLE_INTERVAL - 1);
    always_ff @(posedge fpga_clock)
        count_q <= (reset || tick_o) ? '0 : count_q + 1'b1;
endmodule

// File: rtl/harmonic_sequencer.sv
// harmonic_sequencer: walks the harmonic loop each sample and hands the scaled,
// saturated sum to the DAC on an exact-period tick, flagging missed periods.
module harmonic_sequencer
    import synth_pkg::*;
#(
    parameter int NUM_HARMONICS = NUM_HARMONICS_DEF,
    parameter int DIV_BIT = 7,
    parameter int SAMPLE_INTERVAL = SAMPLE_INTERVAL_DEF,
    parameter logic [DIV_BIT-1:0] MULT_START = DIV_BIT'(127),
    parameter logic signed [31:0] OUTPUT_OFFSET = 32'h31000,
    parameter int OUTPUT_SHIFT = 3
) (
    input  logic fpga_clock,
    input  logic reset,
    input  logic [7:0] i_harmonic_count,
    input  logic [DIV_BIT-1:0] i_mult_step,
    harmonic_sequencer_if.master bus,
    output logic o_overrun,
    output logic o_busy
);
    seq_state_e state_q;
    logic tick, send;
    logic [7:0] harmonic_q, count_q, count_d;
    logic [DIV_BIT-1:0] mult_q, step_q;
    logic signed [31:0] sum_q, scaled;
    logic [15:0] sample_q;
    logic [23:0] dac_q;
    logic next_q, start_q, clear_q, send_q, pending_q, overrun_q;

    sample_tick_gen #(.SAMPLE_INTERVAL(SAMPLE_INTERVAL)) u_tick (
        .fpga_clock(fpga_clock),
        .reset(reset),
        .tick_o(tick)
    );

    assign count_d = (i_harmonic_count > 8'(NUM_HARMONICS)) ? 8'(NUM_HARMONICS) : i_harmonic_count;
    assign scaled = sum_q >>> OUTPUT_SHIFT;
    assign send = (state_q == HOLD) && (tick || pending_q);

    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            state_q <= CLEAR;
            harmonic_q <= '0;
            count_q <= '0;
            step_q <= '0;
            mult_q <= MULT_START;
            sum_q <= '0;
            sample_q <= '0;
            dac_q <= '0;
            next_q <= 1'b0;
            start_q <= 1'b0;
            clear_q <= 1'b0;
            send_q <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            next_q <= 1'b0;
            start_q <= 1'b0;
            clear_q <= 1'b0;
            send_q <= 1'b0;
            // a send consumes any tick arriving in the same cycle
            pending_q <= !send && (tick || pending_q);
            if (tick && pending_q && !send) overrun_q <= 1'b1;
            case (state_q)
                CLEAR: begin
                    clear_q <= 1'b1;
                    harmonic_q <= '0;
                    mult_q <= MULT_START;
                    count_q <= count_d;
                    step_q <= i_mult_step;
                    state_q <= (count_d == '0) ? DRAIN : ISSUE;
                end
                ISSUE: if (bus.i_sample_ready && bus.i_adder_ready) begin
                    start_q <= 1'b1;
                    next_q <= 1'b1;
                    state_q <= GAP;
                end
                // pulses are visible here with the old multiplier; advance afterwards
                GAP: begin
                    harmonic_q <= harmonic_q + 8'd1;
                    mult_q <= (mult_q > step_q) ? mult_q - step_q : mult_q;
                    state_q <= (harmonic_q + 8'd1 == count_q) ? DRAIN : ISSUE;
                end
                DRAIN: if (bus.i_adder_ready) begin
                    sum_q <= bus.i_adder_total + OUTPUT_OFFSET;
                    state_q <= SCALE;
                end
                SCALE: begin
                    sample_q <= sat_u16(scaled);
                    state_q <= HOLD;
                end
                HOLD: if (send) begin
                    dac_q <= {DAC_CMD_CH_A, sample_q};
                    send_q <= 1'b1;
                    state_q <= CLEAR;
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign bus.o_harmonic = harmonic_q;
    assign bus.o_next_sample = next_q;
    assign bus.o_adder_start = start_q;
    assign bus.o_adder_clear = clear_q;
    assign bus.o_adder_mult = mult_q;
    assign bus.o_dac_data = dac_q;
    assign bus.o_dac_send = send_q;
    assign o_overrun = overrun_q;
    assign o_busy = state_q != HOLD;
endmodule
